// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage hazard bus: instruction/EX fields into the hazard controller,
// pipeline enables, flushes and mult/div status back out.
interface pipe_hazard_ctrl_if;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        id_uses_rs;
   logic        id_uses_rt;
   logic        id_is_muldiv;
   logic        id_reads_hilo;
   logic [4:0]  ex_rd;
   logic        ex_mem_read;
   logic        ex_branch_taken;
   logic        pc_write;
   logic        if_id_write;
   logic        if_id_flush;
   logic        id_ex_flush;
   logic        md_start;
   logic        md_busy;
   logic [15:0] stall_cycles;

   modport master (
      output id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_muldiv, id_reads_hilo,
             ex_rd, ex_mem_read, ex_branch_taken,
      input  pc_write, if_id_write, if_id_flush, id_ex_flush, md_start, md_busy,
             stall_cycles
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_muldiv, id_reads_hilo,
             ex_rd, ex_mem_read, ex_branch_taken,
      output pc_write, if_id_write, if_id_flush, id_ex_flush, md_start, md_busy,
             stall_cycles
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall sequencer for the 5-stage MIPS core: load-use bubbles, taken-branch
// squashes and mult/div occupancy tracking with a latency countdown.
module pipe_hazard_ctrl #(
   parameter int MD_LAT = 32,
   parameter int CNT_W  = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   pipe_hazard_ctrl_if.slave hz
);

   typedef enum logic {RUN, BUSY} state_t;

   localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_LAT - 1);

   state_t           state;
   logic [CNT_W-1:0] md_cnt;
   logic [15:0]      stall_cnt;

   logic lu;
   logic mc;
   logic pc_write_c;
   logic if_id_write_c;
   logic if_id_flush_c;
   logic id_ex_flush_c;
   logic md_start_c;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // $0 is hardwired zero, so a load targeting it never creates a dependency.
   always_comb begin
      lu = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
           ((hz.id_uses_rs && (hz.id_rs == hz.ex_rd)) ||
            (hz.id_uses_rt && (hz.id_rt == hz.ex_rd)));
      mc = (state == BUSY) && (hz.id_is_muldiv || hz.id_reads_hilo);

      pc_write_c    = 1'b1;
      if_id_write_c = 1'b1;
      if_id_flush_c = 1'b0;
      id_ex_flush_c = 1'b0;
      md_start_c    = 1'b0;

      // A squashed mult/div must never start, so the branch wins over everything.
      if (hz.ex_branch_taken) begin
         if_id_flush_c = 1'b1;
         id_ex_flush_c = 1'b1;
      end else if (lu || mc) begin
         pc_write_c    = 1'b0;
         if_id_write_c = 1'b0;
         id_ex_flush_c = 1'b1;
      end else if ((state == RUN) && hz.id_is_muldiv) begin
         md_start_c = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         md_cnt    <= '0;
         stall_cnt <= 16'd0;
      end else begin
         case (state)
            RUN: begin
               if (md_start_c) begin
                  state  <= BUSY;
                  md_cnt <= MD_LOAD;
               end
            end
            BUSY: begin
               // The md_cnt==0 cycle is still BUSY; RUN resumes on the following one.
               if (md_cnt == '0) state  <= RUN;
               else              md_cnt <= md_cnt - CNT_W'(1);
            end
            default: state <= RUN;
         endcase
         if (!pc_write_c) stall_cnt <= sat_inc(stall_cnt);
      end
   end

   assign hz.pc_write     = pc_write_c;
   assign hz.if_id_write  = if_id_write_c;
   assign hz.if_id_flush  = if_id_flush_c;
   assign hz.id_ex_flush  = id_ex_flush_c;
   assign hz.md_start     = md_start_c;
   assign hz.md_busy      = (state == BUSY);
   assign hz.stall_cycles = stall_cnt;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard and stall sequencer for the 5-stage MIPS core. It sits between the ID stage and the pipeline registers and drives PC write-enable, IF/ID write-enable and the IF/ID and ID/EX flushes. It resolves three hazard classes:
- load-use hazards, using a one-cycle bubble;
- taken-branch squashes;
- structural/data hazards against the multi-cycle multiply/divide unit, which it starts and tracks with an internal latency counter.

## Interface
Parameters:
- MD_LAT, 32, cycles the mult/div unit needs from start until HI/LO is valid; legal range 1 to 2^CNT_W.
- CNT_W, 6, width of the mult/div countdown counter.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- id_rs  input  5  rs field of the instruction in ID.
- id_rt  input  5  rt field of the instruction in ID.
- id_uses_rs  input  1  ID instruction reads rs.
- id_uses_rt  input  1  ID instruction reads rt.
- id_is_muldiv  input  1  ID instruction is mult/multu/div/divu.
- id_reads_hilo  input  1  ID instruction is mfhi/mflo.
- ex_rd  input  5  destination register of the instruction in EX.
- ex_mem_read  input  1  EX instruction is a load.
- ex_branch_taken  input  1  branch/jump in EX resolved taken.
- pc_write  output  1  PC register write enable.
- if_id_write  output  1  IF/ID register write enable.
- if_id_flush  output  1  zero the IF/ID register at next edge.
- id_ex_flush  output  1  insert a bubble into ID/EX at next edge.
- md_start  output  1  one-cycle start pulse to the mult/div unit.
- md_busy  output  1  mult/div in progress (state BUSY).
- stall_cycles  output  16  saturating count of cycles with pc_write=0.

## Operation
- State register: RUN, BUSY. Countdown md_cnt (CNT_W bits). The control outputs pc_write, if_id_write, if_id_flush, id_ex_flush and md_start are combinational from the current state, md_cnt and the inputs.
- Load-use condition LU = ex_mem_read & (ex_rd != 0) & ((id_uses_rs & id_rs == ex_rd) | (id_uses_rt & id_rt == ex_rd)).
- Mult/div conflict MC = (state == BUSY) & (id_is_muldiv | id_reads_hilo).
- Default outputs: pc_write=1, if_id_write=1, flushes=0, md_start=0.
- Priority, highest first:
  1. ex_branch_taken: if_id_flush=1, id_ex_flush=1, pc_write=1. No stall. md_start=0, because a squashed mult/div never starts.
  2. LU or MC: pc_write=0, if_id_write=0, id_ex_flush=1 (stall one cycle; re-evaluated every cycle).
  3. RUN & id_is_muldiv: md_start=1. Next state is BUSY and md_cnt loads MD_LAT-1.
- BUSY behaviour:
  - Each cycle, if md_cnt != 0, md_cnt decrements.
  - If md_cnt == 0, the next state is RUN. That cycle is still BUSY, so MC stalls apply.
  - Branches flush normally in BUSY and do not abort the mult/div.
  - md_start is never asserted in BUSY.
- md_busy = (state == BUSY).
- stall_cycles increments by 1 on each edge where pc_write == 0, holds at 16'hFFFF, and is never cleared except by reset.
- Register $0 never creates a load-use hazard.

## Timing
- Reset (rst_n low, asynchronous) forces state=RUN, md_cnt=0 and stall_cycles=0. Resulting outputs: md_busy=0, md_start=0, pc_write=1, if_id_write=1, flushes=0, with LU inputs low.
- Reset asserted mid-BUSY aborts tracking immediately. The mult/div unit is reset by the same rst_n.
- Load-use stall length is exactly 1 cycle. On the next cycle the load is in MEM and LU drops because ex_mem_read=0 for the bubble.
- When md_start is asserted in cycle T, md_busy is high for cycles T+1 through T+MD_LAT. A dependent mfhi waiting in ID stalls in each of those cycles and issues at T+MD_LAT+1.
- A second mult/div behind the first stalls the same way and pulses md_start at T+MD_LAT+1.
- Control outputs respond in the same cycle as their inputs. No output is registered except md_busy and stall_cycles.

## Test plan
- Reset, then idle inputs: pc_write=1, if_id_write=1, flushes=0, md_busy=0, stall_cycles=0.
- lw $5 in EX (ex_mem_read=1, ex_rd=5) with add using rs=5 in ID: exactly one cycle of pc_write=0, if_id_write=0, id_ex_flush=1, then stall_cycles=1. Repeat with ex_rd=0: no stall.
- MD_LAT=4: div issued at T gives md_start=1 at T and md_busy=1 for T+1..T+4. An mfhi in ID from T+1 stalls 4 cycles and issues at T+5, and stall_cycles increases by 4.
- Same cycle, ex_branch_taken=1 with LU true and id_is_muldiv=1: if_id_flush=1, id_ex_flush=1, pc_write=1, md_start=0, state stays RUN.
- In BUSY with md_cnt=2, pull rst_n low asynchronously: md_busy drops before the next edge, and stall_cycles=0.
- Force 70000 load-use stalls: stall_cycles saturates at 16'hFFFF and does not wrap.
